app_mult_accum: RTL and testbench
=================================

# app_mult_accum

Downstream accumulation stage for the approximate signed multiplier: consumes the signed product stream of `app_mult_signed` and sums groups of products into one dot-product result. Each group ends after `LEN` products or on an early `prod_last`. The finished result is presented on a valid/ready output port with a sticky overflow flag, then the stage starts the next group.

## Interface
Parameters:
- `PW`, default 16: product width. Equals width1+width2 of the upstream multiplier.
- `AW`, default 24: accumulator and result width. Must be ≥ `PW`.
- `LEN`, default 8: maximum products per group. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset. Releases synchronously to `clk` (external synchroniser).
- `clr`, input, 1: synchronous abort of the current group.
- `prod_valid`, input, 1: product present.
- `prod_ready`, output, 1: stage accepts a product this cycle.
- `prod`, input, `PW`: signed product.
- `prod_last`, input, 1: qualified by `prod_valid`; the accepted product closes the group.
- `acc_valid`, output, 1: result available.
- `acc_ready`, input, 1: consumer takes the result.
- `acc_out`, output, `AW`: signed group sum.
- `acc_ovf`, output, 1: a signed overflow occurred within the group.

## Operation
- FSM has 2 states, encoded in a register. `ACCUM` is the reset state; the other state is `DONE`.
- `prod_ready` = (state == `ACCUM`). `acc_valid` = (state == `DONE`).
- Accept in `ACCUM`: `prod_valid` & `prod_ready`.
  - The product is sign-extended to `AW` and added to `acc`.
  - `cnt` (width $clog2(LEN+1)) increments.
  - `ovf` is set if the signed addition overflows `AW` bits. `ovf` is sticky within the group.
- Group end: an accept with `prod_last`=1, or the accept at which `cnt` reaches `LEN`, moves the FSM to `DONE`.
- `DONE`:
  - `acc_out`/`acc_ovf` are held stable; `prod_ready`=0.
  - On `acc_ready`=1: clear `acc`, `cnt`, and `ovf`, then return to `ACCUM`.
- `acc_out` = `acc` register; `acc_ovf` = `ovf` register. Both are directly registered, with no combinational path from inputs.
- `clr`=1 takes priority over all other events in either state:
  - `acc`, `cnt`, and `ovf` are cleared and the state becomes `ACCUM`.
  - A product offered in the same cycle is dropped (not accumulated), although `prod_ready` was high.
  - A pending result in `DONE` is discarded.
- Arithmetic wraps modulo 2^`AW` (two's complement) unless the configuration macro below is defined.
- `prod_last` outside an accept is ignored.
- With `LEN`=1, every accepted product ends its group.

## Timing
- Reset values: state=`ACCUM`, `prod_ready`=1, `acc_valid`=0, `acc_out`=0, `acc_ovf`=0, `cnt`=0.
- Reset asserted mid-group or in `DONE`: immediate, asynchronous return to the reset values. The partial sum is lost.
- Latency: `acc_valid` rises on the cycle after the group-closing accept.
- Throughput: a group of N products occupies at least N+1 cycles, because the `DONE` cycle accepts no products.
- No bubble inside a group: back-to-back accepts are allowed every cycle.
- Backpressure: `acc_valid` stays high and `acc_out` stays constant for as long as `acc_ready`=0.
- `acc_ready` is not sampled in `ACCUM`.

## Configuration
- `APP_MULT_ACCUM_SAT_EN` defined: on signed overflow, `acc` clamps to the signed extreme of the overflow direction.
  - Upper clamp: 2^(`AW`-1)-1. Lower clamp: -2^(`AW`-1).
  - `acc_ovf` is still set.
  - Subsequent adds continue from the clamped value and are clamped again if they overflow.
- Not defined: two's-complement wrap. `acc_ovf` is still set.

## Test plan
- `LEN`=4, `AW`=24: products 100, -50, 7, -1 on consecutive cycles, `acc_ready`=1 → `acc_valid` high on the 5th cycle, `acc_out`=56, `acc_ovf`=0, then `prod_ready`=1 on the next cycle.
- `LEN`=4: products 3, then 4 with `prod_last`=1 → `acc_out`=7 after 2 accepts; the next group starts from 0.
- Backpressure: hold `acc_ready`=0 for 5 cycles in `DONE` while `prod_valid`=1 → `prod_ready`=0, `acc_out` unchanged, no product consumed. Release → one handshake, then accepts resume.
- `AW`=17, `LEN`=4: product 32767 four times.
  - Without the macro → `acc_out`=-4, `acc_ovf`=1.
  - With `APP_MULT_ACCUM_SAT_EN` → `acc_out`=65535, `acc_ovf`=1.
- `clr` after 2 accepted products (10, 20), with a valid product 5 offered in the `clr` cycle → 5 is not counted. Products 1, 2, 3, 4 then give `acc_out`=10.
- `rst_n` low mid-group and again while in `DONE` → outputs take their reset values immediately (`acc_valid`=0, `acc_out`=0, `prod_ready`=1). After release, the next full group sums correctly.

Source files
------------

// File: rtl/app_mult_accum.sv
// ---------------------------------------------------------------------------
// app_mult_accum
// Accumulates groups of signed products from the approximate signed
// multiplier into a single dot-product result. A group closes after LEN
// accepted products or on an accepted product flagged prod_last; the sum is
// then held on a valid/ready port, together with a sticky overflow flag,
// until the consumer takes it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort of the current group (top priority)
//   prod_valid/ready    product input handshake
//   prod [PW]           signed product
//   prod_last           accepted product closes the group
//   acc_valid/ready     result output handshake
//   acc_out [AW]        signed group sum (registered)
//   acc_ovf             signed overflow seen in the group (registered)
//
// Configuration macro:
//   APP_MULT_ACCUM_SAT_EN  defined   -> overflowing adds clamp to the signed
//                                       extreme of the overflow direction
//                          undefined -> two's-complement wrap
// ---------------------------------------------------------------------------
module app_mult_accum #(
    parameter int unsigned PW  = 16,
    parameter int unsigned AW  = 24,
    parameter int unsigned LEN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          prod_valid,
    output logic          prod_ready,
    input  logic [PW-1:0] prod,
    input  logic          prod_last,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [AW-1:0] acc_out,
    output logic          acc_ovf
);

    localparam int unsigned   CW       = $clog2(LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [AW-1:0] ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN  = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          ovf_q,   ovf_d;

    logic [AW-1:0] prod_ext;
    logic [AW-1:0] sum;
    logic [AW-1:0] add_res;
    logic          add_ovf;
    logic          group_end;

    // Sign-extend the product and detect signed overflow of the add:
    // operands share a sign and the result's sign differs from it.
    assign prod_ext  = AW'($signed(prod));
    assign sum       = acc_q + prod_ext;
    assign add_ovf   = (acc_q[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
    assign group_end = prod_last || (cnt_q == CNT_LAST);

`ifdef APP_MULT_ACCUM_SAT_EN
    // Clamp toward the direction of overflow; the operands' common sign tells which.
    assign add_res = add_ovf ? (acc_q[AW-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign add_res = sum;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; clr overrides everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (prod_valid) begin
                        acc_d = add_res;
                        cnt_d = cnt_q + CW'(1);
                        ovf_d = ovf_q | add_ovf;
                        if (group_end) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // Handshake flags decode the single state flop directly.
    assign prod_ready = (state_q == ACCUM);
    assign acc_valid  = (state_q == DONE);
    assign acc_out    = acc_q;
    assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_app_mult_accum.sv
// ---------------------------------------------------------------------------
// tb_app_mult_accum
// Self-checking bench for app_mult_accum. A main instance (AW=24, LEN=4)
// covers grouping, backpressure, clr and reset; a second instance (AW=17,
// LEN=4) covers overflow. Expected group results come from a behavioural
// model and are queued as stimulus is driven, then popped when the DUT
// presents its result.
// ---------------------------------------------------------------------------
module tb_app_mult_accum;

    localparam int unsigned PW = 16;
`ifdef APP_MULT_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        longint sum;
        bit     ovf;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [PW-1:0] prod;
    logic          prod_last;
    logic          acc_ready;

    logic          m_valid, m_ready, m_avalid, m_ovf;
    logic [23:0]   m_out;
    logic          o_valid, o_ready, o_avalid, o_ovf;
    logic [16:0]   o_out;

    int   total;
    int   bad;
    exp_t sb_q[$];
    exp_t e;
    int   pq[$];

    app_mult_accum #(.PW(PW), .AW(24), .LEN(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .prod_valid (m_valid),
        .prod_ready (m_ready),
        .prod       (prod),
        .prod_last  (prod_last),
        .acc_valid  (m_avalid),
        .acc_ready  (acc_ready),
        .acc_out    (m_out),
        .acc_ovf    (m_ovf)
    );

    app_mult_accum #(.PW(PW), .AW(17), .LEN(4)) u_ovf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .prod_valid (o_valid),
        .prod_ready (o_ready),
        .prod       (prod),
        .prod_last  (prod_last),
        .acc_valid  (o_avalid),
        .acc_ready  (acc_ready),
        .acc_out    (o_out),
        .acc_ovf    (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference group sum over aw bits, wrapping or saturating on overflow.
    function automatic exp_t model(input int p[$], input int aw, input bit sat);
        exp_t   r;
        longint mx;
        longint mn;
        longint s;
        mx    = (longint'(1) <<< (aw - 1)) - 1;
        mn    = -(longint'(1) <<< (aw - 1));
        s     = 0;
        r.ovf = 1'b0;
        foreach (p[i]) begin
            s = s + longint'(p[i]);
            if (s > mx) begin
                r.ovf = 1'b1;
                s = sat ? mx : s - (longint'(1) <<< aw);
            end else if (s < mn) begin
                r.ovf = 1'b1;
                s = sat ? mn : s + (longint'(1) <<< aw);
            end
        end
        r.sum = s;
        return r;
    endfunction

    // Offer one product for one clock edge; sel picks the overflow instance.
    task automatic drive(input int p, input bit last, input bit sel);
        if (sel) o_valid = 1'b1;
        else     m_valid = 1'b1;
        prod      = PW'(p);
        prod_last = last;
        @(posedge clk); #1;
        m_valid   = 1'b0;
        o_valid   = 1'b0;
        prod_last = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_prod_ready: got %b want 1", m_ready); end
        total++; if (m_avalid !== 1'b0) begin bad++; $display("FAIL reset_acc_valid: got %b want 0", m_avalid); end
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL reset_acc_out: got %0d want 0", $signed(m_out)); end
        total++; if (m_ovf !== 1'b0) begin bad++; $display("FAIL reset_acc_ovf: got %b want 0", m_ovf); end
    endtask

    task automatic test_full_group;
        acc_ready = 1'b1;
        pq = {100, -50, 7, -1};
        sb_q.push_back(model(pq, 24, SAT));
        foreach (pq[i]) begin
            total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL full_prod_ready[%0d]: got %b want 1", i, m_ready); end
            drive(pq[i], 1'b0, 1'b0);
        end
        total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL full_latency: acc_valid got %b want 1", m_avalid); end
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL full_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL full_sum: got %0d want %0d", $signed(m_out), e.sum); end
            total++; if (m_ovf !== e.ovf) begin bad++; $display("FAIL full_ovf: got %b want %b", m_ovf, e.ovf); end
        end
        @(posedge clk); #1;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL full_resume: prod_ready got %b want 1", m_ready); end
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL full_cleared: got %0d want 0", $signed(m_out)); end
    endtask

    task automatic test_early_last;
        acc_ready = 1'b1;
        pq = {3, 4};
        sb_q.push_back(model(pq, 24, SAT));
        drive(3, 1'b0, 1'b0);
        total++; if (m_avalid !== 1'b0) begin bad++; $display("FAIL early_mid_valid: got %b want 0", m_avalid); end
        drive(4, 1'b1, 1'b0);
        total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL early_valid: got %b want 1", m_avalid); end
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL early_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL early_sum: got %0d want %0d", $signed(m_out), e.sum); end
        end
        @(posedge clk); #1;
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL early_next_zero: got %0d want 0", $signed(m_out)); end
    endtask

    task automatic test_backpressure;
        acc_ready = 1'b0;
        pq = {1, 2, 3, 4};
        e = model(pq, 24, SAT);
        foreach (pq[i]) drive(pq[i], 1'b0, 1'b0);
        m_valid = 1'b1;
        prod    = PW'(99);
        for (int k = 0; k < 5; k++) begin
            total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL bp_prod_ready[%0d]: got %b want 0", k, m_ready); end
            total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL bp_acc_valid[%0d]: got %b want 1", k, m_avalid); end
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL bp_hold[%0d]: got %0d want %0d", k, $signed(m_out), e.sum); end
            @(posedge clk); #1;
        end
        acc_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (m_avalid !== 1'b0) begin bad++; $display("FAIL bp_release: acc_valid got %b want 0", m_avalid); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL bp_resume: prod_ready got %b want 1", m_ready); end
        pq = {99, 5};
        sb_q.push_back(model(pq, 24, SAT));
        @(posedge clk); #1;
        m_valid = 1'b0;
        drive(5, 1'b1, 1'b0);
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL bp_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL bp_next_valid: got %b want 1", m_avalid); end
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL bp_next_sum: got %0d want %0d", $signed(m_out), e.sum); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr;
        acc_ready = 1'b1;
        drive(10, 1'b0, 1'b0);
        drive(20, 1'b0, 1'b0);
        clr     = 1'b1;
        m_valid = 1'b1;
        prod    = PW'(5);
        @(posedge clk); #1;
        clr     = 1'b0;
        m_valid = 1'b0;
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL clr_acc: got %0d want 0", $signed(m_out)); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b want 1", m_ready); end
        pq = {1, 2, 3, 4};
        sb_q.push_back(model(pq, 24, SAT));
        foreach (pq[i]) drive(pq[i], 1'b0, 1'b0);
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL clr_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL clr_group_valid: got %b want 1", m_avalid); end
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL clr_group_sum: got %0d want %0d", $signed(m_out), e.sum); end
        end
        @(posedge clk); #1;
        // Abort a pending result in DONE.
        acc_ready = 1'b0;
        drive(9, 1'b1, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        total++; if (m_avalid !== 1'b0) begin bad++; $display("FAIL clr_done_valid: got %b want 0", m_avalid); end
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL clr_done_acc: got %0d want 0", $signed(m_out)); end
    endtask

    task automatic test_reset_mid;
        acc_ready = 1'b0;
        drive(7, 1'b0, 1'b0);
        drive(8, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL rst_mid_acc: got %0d want 0", $signed(m_out)); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", m_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pq = {5, 6, 7, 8};
        foreach (pq[i]) drive(pq[i], 1'b0, 1'b0);
        total++; if (m_avalid !== 1'b1) begin bad++; $display("FAIL rst_pre_done: got %b want 1", m_avalid); end
        rst_n = 1'b0;
        #1;
        total++; if (m_avalid !== 1'b0) begin bad++; $display("FAIL rst_done_valid: got %b want 0", m_avalid); end
        total++; if (m_out !== 24'd0) begin bad++; $display("FAIL rst_done_acc: got %0d want 0", $signed(m_out)); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL rst_done_ready: got %b want 1", m_ready); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        acc_ready = 1'b1;
        pq = {1000, -2000, 3, -4};
        sb_q.push_back(model(pq, 24, SAT));
        foreach (pq[i]) drive(pq[i], 1'b0, 1'b0);
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL rst_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (m_out !== 24'(e.sum)) begin bad++; $display("FAIL rst_after_sum: got %0d want %0d", $signed(m_out), e.sum); end
            total++; if (m_ovf !== e.ovf) begin bad++; $display("FAIL rst_after_ovf: got %b want %b", m_ovf, e.ovf); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        acc_ready = 1'b1;
        pq = {32767, 32767, 32767, 32767};
        sb_q.push_back(model(pq, 17, SAT));
        drive(32767, 1'b0, 1'b1);
        drive(32767, 1'b0, 1'b1);
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", o_ovf); end
        drive(32767, 1'b0, 1'b1);
        drive(32767, 1'b0, 1'b1);
        if (sb_q.size() == 0) begin total++; bad++; $display("FAIL ovf_sb: got empty want entry"); end
        else begin
            e = sb_q.pop_front();
            total++; if (o_avalid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", o_avalid); end
            total++; if (o_out !== 17'(e.sum)) begin bad++; $display("FAIL ovf_sum: got %0d want %0d", $signed(o_out), e.sum); end
            total++; if (o_ovf !== e.ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", o_ovf, e.ovf); end
        end
        @(posedge clk); #1;
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b want 0", o_ovf); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        prod      = '0;
        prod_last = 1'b0;
        acc_ready = 1'b0;
        m_valid   = 1'b0;
        o_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_full_group;
        test_early_last;
        test_backpressure;
        test_clr;
        test_reset_mid;
        test_overflow;
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_drained: got %0d want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
